ham74_dec_sched: RTL and testbench
==================================

# ham74_dec_sched

Round-robin scheduler that shares one Hamming(7,4) syndrome/correction pipeline between NREQ requesters. Each requester offers a 7-bit received codeword over a valid/ready handshake. The block computes the 3-bit syndrome, corrects any single-bit error and returns the 4 data bits tagged with the requester ID over a single valid/ready output port. It sits between the channel-side receive buffers and the downstream data consumer.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), requester ID width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  NREQ  per-requester codeword valid
- req_code  in  7*NREQ  codewords; requester i occupies bits [7i+6:7i]
- req_ready  out  NREQ  per-requester accept; at most one bit high
- out_valid  out  1  result valid
- out_ready  in  1  consumer accept
- out_id  out  IDW  requester index of result
- out_data  out  4  corrected data: {c[0],c[1],c[2],c[4]}
- out_syndrome  out  3  syndrome of received word
- out_corrected  out  1  syndrome nonzero, one bit flipped
- busy  out  1  any pipeline stage holds a valid entry
- err_clr  in  1  synchronous clear of err_cnt (HAM_ERR_CNT_EN only)
- err_cnt  out  16  saturating corrected-error count (HAM_ERR_CNT_EN only)

## Operation
- Syndrome definition:
  - s[2] = c3^c2^c1^c0
  - s[1] = c5^c4^c1^c0
  - s[0] = c6^c4^c2^c0
- Syndrome value s≠0 identifies bit index 7−s, which is inverted before data extraction. s=0 passes the word unchanged.
- Parity positions are c3, c5 and c6. Double errors alias to a single-bit correction; this is not detected.
- Three-stage pipeline:
  - ISSUE: registers code and ID
  - SYND: registers syndrome, code and ID
  - OUT: registers corrected data, syndrome, flag and ID
  - Each stage has its own valid bit.
- advance = !out_valid | out_ready. All stages shift together on advance and hold otherwise. Bubbles propagate as cleared valid bits.
- Arbitration:
  - Combinational round-robin over req_valid, starting at (last+1) mod NREQ.
  - req_ready[g] = grant[g] & advance.
  - Transfer occurs when req_valid[i] & req_ready[i].
  - The last pointer updates only on a transfer.
  - Requesters must not make req_valid depend on req_ready.
- An offered req_code must stay stable until accepted. No requester is starved: wait is at most NREQ−1 transfers.

## Timing
- Reset values:
  - out_valid=0, out_id=0, out_data=0, out_syndrome=0, out_corrected=0
  - all stage valids=0, busy=0, err_cnt=0
  - last pointer=NREQ−1, so requester 0 wins first.
- Latency: a transfer on edge k produces out_valid=1 after edge k+2, provided out_ready stayed high.
- Throughput: one result per cycle while out_ready=1 and requests are pending.
- Backpressure:
  - out_valid=1 with out_ready=0 freezes all stages and output registers, and forces req_ready=0.
  - Output data is stable while stalled.
- Simultaneous out_ready rise and a new request: the entry is accepted on the same edge the output is consumed. No bubble is inserted.
- Reset asserted mid-operation:
  - All in-flight entries are discarded immediately and asynchronously.
  - Outputs return to reset values.
  - Nothing is replayed.

## Configuration
- HAM_ERR_CNT_EN defined:
  - err_cnt increments by 1 on each output handshake (out_valid & out_ready) with out_corrected=1.
  - It saturates at 16'hFFFF.
  - err_clr=1 zeroes it on the next edge; clear wins over a simultaneous increment.
- HAM_ERR_CNT_EN undefined:
  - err_cnt and err_clr ports and their logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then requester 0 sends 7'h69 (data 1000, clean) with out_ready=1:
  - req_ready[0] is high on the transfer edge.
  - Two edges later: out_valid=1, out_id=0, out_data=4'b1000, out_syndrome=0, out_corrected=0.
- Requester 2 sends 7'h79 (7'h69 with bit 4 flipped): out_syndrome=3, out_corrected=1, out_data=4'b1000, out_id=2.
- All four requesters hold req_valid=1 continuously: grants follow order 0,1,2,3,0,…, with one result per cycle after a 2-edge fill.
- out_ready held low for 5 cycles with 3 entries in flight:
  - req_ready stays 0 and out_* is stable.
  - After release, results appear on 3 consecutive cycles in order with no loss or duplication.
- rst driven low while busy=1: out_valid and busy go 0 without a clock edge. After release, requester 0 wins first.
- With HAM_ERR_CNT_EN:
  - 3 corrected results give err_cnt=3.
  - err_clr pulsed together with a corrected handshake gives err_cnt=0.
  - Preloading 16'hFFFF via force and sending a corrected result leaves err_cnt=16'hFFFF.

Source files
------------

// File: rtl/ham74_dec_sched.sv
// Round-robin scheduler sharing one Hamming(7,4) syndrome/correction pipeline between NREQ requesters.
// Optional saturating corrected-error counter enabled by defining HAM_ERR_CNT_EN.
module ham74_dec_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [7*NREQ-1:0] i_req_code,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [IDW-1:0]    o_out_id,
    output logic [3:0]        o_out_data,
    output logic [2:0]        o_out_syndrome,
    output logic              o_out_corrected,
    output logic              o_busy
`ifdef HAM_ERR_CNT_EN
    ,
    input  logic              i_err_clr,
    output logic [15:0]       o_err_cnt
`endif
);

    function automatic logic [2:0] f_synd(input logic [6:0] c);
        return {c[3] ^ c[2] ^ c[1] ^ c[0],
                c[5] ^ c[4] ^ c[1] ^ c[0],
                c[6] ^ c[4] ^ c[2] ^ c[0]};
    endfunction

    logic [IDW-1:0]  r_last;
    logic            r_iss_vld;
    logic [6:0]      r_iss_code;
    logic [IDW-1:0]  r_iss_id;
    logic            r_syn_vld;
    logic [6:0]      r_syn_code;
    logic [IDW-1:0]  r_syn_id;
    logic [2:0]      r_syn_s;
    logic            r_out_vld;
    logic [IDW-1:0]  r_out_id;
    logic [3:0]      r_out_data;
    logic [2:0]      r_out_s;
    logic            r_out_corr;

    logic            w_adv;
    logic            w_found;
    logic [IDW-1:0]  w_gnt_id;
    logic [IDW-1:0]  w_idx;
    logic [NREQ-1:0] w_grant;
    logic            w_xfer;
    logic [6:0]      w_code;
    logic [6:0]      w_fixed;

    assign w_adv = !r_out_vld || i_out_ready;

    // Search starts one past the last winner and wraps at NREQ-1.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = r_last;
        w_grant  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            if (!w_found && i_req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
        w_grant[w_gnt_id] = w_found;
    end

    assign o_req_ready = w_grant & {NREQ{w_adv}};
    assign w_xfer      = w_found && w_adv;

    always_comb begin
        w_code = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt_id == IDW'(k)) w_code = i_req_code[7*k +: 7];
        end
    end

    // Nonzero syndrome s points at bit 7-s; flip it before extracting data.
    always_comb begin
        w_fixed = r_syn_code;
        if (r_syn_s != 3'd0) w_fixed[3'd7 - r_syn_s] = ~r_syn_code[3'd7 - r_syn_s];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last     <= IDW'(NREQ - 1);
            r_iss_vld  <= 1'b0;
            r_iss_code <= '0;
            r_iss_id   <= '0;
            r_syn_vld  <= 1'b0;
            r_syn_code <= '0;
            r_syn_id   <= '0;
            r_syn_s    <= '0;
            r_out_vld  <= 1'b0;
            r_out_id   <= '0;
            r_out_data <= '0;
            r_out_s    <= '0;
            r_out_corr <= 1'b0;
        end else begin
            if (w_xfer) r_last <= w_gnt_id;
            if (w_adv) begin
                r_iss_vld <= w_xfer;
                if (w_xfer) begin
                    r_iss_code <= w_code;
                    r_iss_id   <= w_gnt_id;
                end
                r_syn_vld <= r_iss_vld;
                if (r_iss_vld) begin
                    r_syn_code <= r_iss_code;
                    r_syn_id   <= r_iss_id;
                    r_syn_s    <= f_synd(r_iss_code);
                end
                r_out_vld <= r_syn_vld;
                if (r_syn_vld) begin
                    r_out_id   <= r_syn_id;
                    r_out_data <= {w_fixed[0], w_fixed[1], w_fixed[2], w_fixed[4]};
                    r_out_s    <= r_syn_s;
                    r_out_corr <= (r_syn_s != 3'd0);
                end
            end
        end
    end

    assign o_out_valid     = r_out_vld;
    assign o_out_id        = r_out_id;
    assign o_out_data      = r_out_data;
    assign o_out_syndrome  = r_out_s;
    assign o_out_corrected = r_out_corr;
    assign o_busy          = r_iss_vld || r_syn_vld || r_out_vld;

`ifdef HAM_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
        end else if (i_err_clr) begin
            r_err_cnt <= '0;
        end else if (r_out_vld && i_out_ready && r_out_corr && r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_ham74_dec_sched.sv
// Bench for ham74_dec_sched: directed scenarios followed by random traffic, all checked
// against a transaction-level model (round-robin winner search plus a 3-slot latency line).
module tb_ham74_dec_sched;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [7*N-1:0] req_code = '0;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [IW-1:0]  out_id;
    logic [3:0]     out_data;
    logic [2:0]     out_syndrome;
    logic           out_corrected;
    logic           busy;
`ifdef HAM_ERR_CNT_EN
    logic           err_clr = 1'b0;
    logic [15:0]    err_cnt;
    logic [15:0]    m_cnt;
`endif

    ham74_dec_sched #(.NREQ(N), .IDW(IW)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .i_req_code      (req_code),
        .o_req_ready     (req_ready),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_id        (out_id),
        .o_out_data      (out_data),
        .o_out_syndrome  (out_syndrome),
        .o_out_corrected (out_corrected),
        .o_busy          (busy)
`ifdef HAM_ERR_CNT_EN
        ,
        .i_err_clr       (err_clr),
        .o_err_cnt       (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [6:0] rc[N];
    logic       m_vld[3];
    int         m_id[3];
    logic [6:0] m_code[3];
    int         m_last;
    int         m_xfer;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {corrected, syndrome[2:0], data[3:0]}.
    function automatic logic [7:0] ref_dec(input logic [6:0] c);
        logic [6:0] w;
        int s;
        s = 4 * (c[3] ^ c[2] ^ c[1] ^ c[0]) + 2 * (c[5] ^ c[4] ^ c[1] ^ c[0]) + (c[6] ^ c[4] ^ c[2] ^ c[0]);
        w = c;
        if (s != 0) w[7 - s] = ~w[7 - s];
        return {s != 0, 3'(s), w[0], w[1], w[2], w[4]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_vld[i] = 1'b0;
            m_id[i] = 0;
            m_code[i] = '0;
        end
        m_last = N - 1;
        m_xfer = -1;
`ifdef HAM_ERR_CNT_EN
        m_cnt = '0;
`endif
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) req_code[7*i +: 7] = rc[i];
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    // Check everything at mid-cycle, take one clock edge, advance the model.
    task automatic tick();
        int win;
        logic adv;
        logic [7:0] d;
        logic [N-1:0] er;
        settle();
        adv = !m_vld[2] || out_ready;
        d = ref_dec(m_code[2]);
        chk("out_valid", out_valid, m_vld[2]);
        chk("busy", busy, m_vld[0] || m_vld[1] || m_vld[2]);
        if (m_vld[2]) begin
            chk("out_id", out_id, m_id[2]);
            chk("out_data", out_data, d[3:0]);
            chk("out_syndrome", out_syndrome, d[6:4]);
            chk("out_corrected", out_corrected, d[7]);
        end
        win = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (win < 0 && req_valid[i]) win = i;
        end
        er = '0;
        if (adv && win >= 0) er[win] = 1'b1;
        chk("req_ready", req_ready, er);
`ifdef HAM_ERR_CNT_EN
        chk("err_cnt", err_cnt, m_cnt);
`endif
        @(posedge clk);
`ifdef HAM_ERR_CNT_EN
        if (err_clr) m_cnt = '0;
        else if (m_vld[2] && out_ready && d[7] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
        m_xfer = -1;
        if (adv) begin
            for (int s = 2; s > 0; s--) begin
                m_vld[s] = m_vld[s-1];
                m_id[s] = m_id[s-1];
                m_code[s] = m_code[s-1];
            end
            m_vld[0] = (win >= 0);
            if (win >= 0) begin
                m_id[0] = win;
                m_code[0] = rc[win];
                m_last = win;
                m_xfer = win;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] one;
        one = 4'b0001;
        for (int i = 0; i < N; i++) rc[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_syndrome", out_syndrome, 0);
        chk("rst_out_corrected", out_corrected, 0);
`ifdef HAM_ERR_CNT_EN
        chk("rst_err_cnt", err_cnt, 0);
`endif
        rst_n = 1'b1;

        // Clean word from requester 0, latency 2 edges.
        rc[0] = 7'h69;
        req_valid = 4'b0001;
        settle();
        chk("t1_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        chk("t1_lat_early", out_valid, 0);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_id", out_id, 0);
        chk("t1_data", out_data, 4'b1000);
        chk("t1_syn", out_syndrome, 0);
        chk("t1_corr", out_corrected, 0);
        tick();

        // Single-bit error on c4 from requester 2.
        rc[2] = 7'h79;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t2_valid", out_valid, 1);
        chk("t2_id", out_id, 2);
        chk("t2_data", out_data, 4'b1000);
        chk("t2_syn", out_syndrome, 3);
        chk("t2_corr", out_corrected, 1);
        tick();

        // All requesters busy: grants rotate starting after the last winner (2).
        for (int i = 0; i < N; i++) rc[i] = 7'($urandom);
        req_valid = 4'hF;
        for (int j = 0; j < 8; j++) begin
            settle();
            chk("rr_order", req_ready, one << ((3 + j) % N));
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Backpressure with three entries in flight.
        req_valid = 4'hF;
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (5) begin
            settle();
            chk("bp_ready", req_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        req_valid = '0;
        repeat (4) tick();

        // Asynchronous reset while busy.
        req_valid = 4'hF;
        repeat (2) tick();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_out_data", out_data, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("arst_first_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (3) tick();

`ifdef HAM_ERR_CNT_EN
        // Corrected-error counter: count, clear-wins, saturation.
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rc[2] = 7'h79;
        req_valid = 4'b0100;
        repeat (3) tick();
        req_valid = '0;
        repeat (3) tick();
        chk("ec_three", err_cnt, 3);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (2) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ec_clr_wins", err_cnt, 0);
        force dut.r_err_cnt = 16'hFFFF;
        #1 release dut.r_err_cnt;
        m_cnt = 16'hFFFF;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (3) tick();
        chk("ec_saturate", err_cnt, 16'hFFFF);
`endif

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    rc[i] = 7'($urandom);
                end
            end
`ifdef HAM_ERR_CNT_EN
            err_clr = ($urandom_range(0, 19) == 0);
`endif
            tick();
            if (m_xfer >= 0) req_valid[m_xfer] = 1'b0;
        end
`ifdef HAM_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        out_ready = 1'b1;
        req_valid = '0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
